// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE,
    MD_BUSY
  } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy tracker: busy for exactly MD_LATENCY cycles after the last issue edge.
module md_busy_timer
  import pipeline_hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic busy
);

  localparam int unsigned CntW = $clog2(MD_LATENCY);
  localparam logic [CntW-1:0] Reload = CntW'(MD_LATENCY - 1);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_q <= MD_BUSY;
            cnt_q   <= Reload;
            busy    <= 1'b1;
          end
        end
        MD_BUSY: begin
          // A back-to-back issue restarts the full latency window.
          if (md_start) begin
            cnt_q <= Reload;
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use and mult/div stalls,
// branch/jump flushes, and a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_uses_rt_i,
  input  logic                  ifid_md_use_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  input  logic                  md_start_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  output logic                  pc_hold_o,
  output logic                  ifid_hold_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  md_busy_o,
  output logic [CNT_W-1:0]      stall_count_o
);

  logic md_busy;
  logic load_use;
  logic md_stall;
  logic stall;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_timer (
    .clk     (clk),
    .reset   (reset),
    .md_start(md_start_i),
    .busy    (md_busy)
  );

  assign md_busy_o = md_busy;

  assign load_use = idex_mem_read_i && (idex_rt_i != REG_ZERO) &&
                    ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
  assign md_stall = md_busy && ifid_md_use_i;
  assign stall    = load_use || md_stall;

  // The redirect outranks any stall; a stalled jump waits until the stall clears.
  always_comb begin
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    if (!reset) begin
      pc_hold_o     = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (stall) begin
      pc_hold_o     = 1'b1;
      ifid_hold_o   = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (jump_i) begin
      ifid_flush_o  = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (pc_hold_o && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MD_LATENCY=4, CNT_W=4).
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, ifid_md_use, idex_mem_read, md_start, branch_taken, jump;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, md_busy;
  logic [3:0] stall_count;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller #(
    .MD_LATENCY(4),
    .CNT_W     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .ifid_uses_rt_i (ifid_uses_rt),
    .ifid_md_use_i  (ifid_md_use),
    .idex_mem_read_i(idex_mem_read),
    .idex_rt_i      (idex_rt),
    .md_start_i     (md_start),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .pc_hold_o      (pc_hold),
    .ifid_hold_o    (ifid_hold),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .md_busy_o      (md_busy),
    .stall_count_o  (stall_count)
  );

  always #5 clk = ~clk;

  // Expected flags packed as {pc_hold, ifid_hold, ifid_flush, idex_bubble, md_busy}.
  task automatic chk_out(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    #1;
    obs = {pc_hold, ifid_hold, ifid_flush, idex_bubble, md_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: flags observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (stall_count === exp) else begin
      errors++;
      $error("FAIL %s: stall_count observed=%0d expected=%0d", tag, stall_count, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    ifid_uses_rt = 1'b0; ifid_md_use = 1'b0; idex_mem_read = 1'b0;
    md_start = 1'b0; branch_taken = 1'b0; jump = 1'b0;
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    // Stall-causing inputs during reset must not reach the outputs.
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; branch_taken = 1'b1;
    #12;
    chk_out("reset_forced_zero", 5'b00000);
    chk_cnt("reset_cnt", 4'd0);
    clear_in();
    step();
    reset = 1'b1;
    chk_out("after_release_idle", 5'b00000);

    // 1. Load-use on rs
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
    chk_out("load_use_rs", 5'b11010);
    chk_cnt("load_use_cnt_before", 4'd0);
    step();
    idex_mem_read = 1'b0;
    chk_out("load_use_one_cycle", 5'b00000);
    chk_cnt("load_use_cnt_after", 4'd1);

    // 2. rt match gated by uses_rt, and loads to $zero
    idex_mem_read = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; ifid_rs = 5'd3; ifid_uses_rt = 1'b0;
    chk_out("rt_match_no_use", 5'b00000);
    ifid_uses_rt = 1'b1;
    chk_out("rt_match_use", 5'b11010);
    idex_rt = 5'd0; ifid_rt = 5'd0; ifid_rs = 5'd0;
    chk_out("load_to_zero", 5'b00000);
    clear_in();
    step();
    chk_cnt("no_stall_cnt", 4'd1);

    // 3. Mult/div occupancy with a second issue in busy cycle 2
    md_start = 1'b1; ifid_md_use = 1'b1;
    chk_out("md_issue_cycle", 5'b00000);
    step();
    md_start = 1'b0;
    chk_out("md_busy_c1", 5'b11011);
    step();
    md_start = 1'b1;
    chk_out("md_busy_c2", 5'b11011);
    step();
    md_start = 1'b0; ifid_md_use = 1'b0;
    chk_out("md_busy_c3_no_use", 5'b00001);
    ifid_md_use = 1'b1;
    chk_out("md_busy_c3", 5'b11011);
    step();
    chk_out("md_busy_c4", 5'b11011);
    step();
    chk_out("md_busy_c5", 5'b11011);
    step();
    chk_out("md_busy_c6", 5'b11011);
    step();
    chk_out("md_idle_c7", 5'b00000);
    chk_cnt("md_cnt", 4'd7);
    clear_in();

    // 4. Branch beats load-use; jump waits out a stall
    idex_mem_read = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; branch_taken = 1'b1;
    chk_out("branch_over_stall", 5'b00110);
    step();
    branch_taken = 1'b0; jump = 1'b1;
    chk_cnt("branch_no_count", 4'd7);
    chk_out("jump_during_stall", 5'b11010);
    step();
    idex_mem_read = 1'b0;
    chk_out("jump_after_stall", 5'b00100);
    chk_cnt("jump_stall_cnt", 4'd8);
    clear_in();
    md_start = 1'b1; branch_taken = 1'b1;
    chk_out("md_start_with_branch", 5'b00110);
    step();
    clear_in();
    chk_out("md_busy_after_branch", 5'b00001);

    // 6. Asynchronous reset in the middle of MD_BUSY
    ifid_md_use = 1'b1;
    chk_out("md_stall_pre_reset", 5'b11011);
    #1;
    reset = 1'b0;
    chk_out("async_reset_outputs", 5'b00000);
    chk_cnt("async_reset_cnt", 4'd0);
    step();
    reset = 1'b1;
    chk_out("post_reset_md_idle", 5'b00000);
    chk_cnt("post_reset_cnt", 4'd0);
    clear_in();

    // 5. Saturation: 2^4+3 stall cycles
    idex_mem_read = 1'b1; idex_rt = 5'd12; ifid_rs = 5'd12;
    for (int i = 0; i < 14; i++) step();
    chk_cnt("sat_cnt_14", 4'd14);
    step();
    chk_cnt("sat_cnt_15", 4'd15);
    for (int i = 0; i < 4; i++) step();
    chk_out("sat_still_stalling", 5'b11010);
    chk_cnt("sat_cnt_stuck", 4'hF);
    clear_in();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim did not finish, observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
